keypad_scanner: RTL

//  Input-side counterpart of the multiplexed 7-segment driver: scans a 4x4 matrix keypad
//  (Pmod KYPD) by strobing one column low at a time and reading the active-low rows.

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/keypad_scanner_if.sv | 18 +
 rtl/keypad_debounce_fsm.sv | 117 +++++++++++
 rtl/keypad_scanner.sv | 103 ++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    S_RELEASED,
    S_PRESS_CHK,
    S_PRESSED,
    S_RELEASE_CHK
  } deb_state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Pmod KYPD legend: rows top to bottom, columns left to right.
  function automatic logic [3:0] key_lut(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'h0;
      4'hD:    code = 4'hF;
      4'hE:    code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Pin-side and user-side signals of the keypad scanner.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pulse;

  modport master (
    input  row,
    output col, key_code, key_valid, key_pulse
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_pulse
  );
endinterface

// File: rtl/keypad_debounce_fsm.sv
// Frame-level debounce: a key change is accepted only after DEBOUNCE_FRAMES
// consecutive agreeing frame results.
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       frame_valid,
  input  logic [3:0] frame_code,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_FRAMES);

  deb_state_t       state_q, state_d;
  logic [3:0]       cand_q, cand_d, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             valid_d, pulse_d;
  logic             match_cand, match_key;

  assign cnt_inc    = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + CNT_ONE;
  assign match_cand = frame_valid && (frame_code == cand_q);
  assign match_key  = frame_valid && (frame_code == key_code);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RELEASED;
      cand_q    <= '0;
      cnt_q     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      key_code  <= code_d;
      key_valid <= valid_d;
      key_pulse <= pulse_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = key_code;
    valid_d = key_valid;
    pulse_d = 1'b0;
    if (frame_tick) begin
      case (state_q)
        S_RELEASED: begin
          if (frame_valid) begin
            if (CNT_ONE == CNT_DONE) begin
              state_d = S_PRESSED;
              code_d  = frame_code;
              valid_d = 1'b1;
              pulse_d = 1'b1;
            end else begin
              state_d = S_PRESS_CHK;
              cand_d  = frame_code;
              cnt_d   = CNT_ONE;
            end
          end
        end
        S_PRESS_CHK: begin
          if (!frame_valid) begin
            state_d = S_RELEASED;
          end else if (match_cand) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d = S_PRESSED;
              code_d  = cand_q;
              valid_d = 1'b1;
              pulse_d = 1'b1;
            end
          end else begin
            cand_d = frame_code;
            cnt_d  = CNT_ONE;
          end
        end
        S_PRESSED: begin
          if (!match_key) begin
            cnt_d = CNT_ONE;
            if (CNT_ONE == CNT_DONE) begin
              state_d = S_RELEASED;
              valid_d = 1'b0;
            end else begin
              state_d = S_RELEASE_CHK;
            end
          end
        end
        S_RELEASE_CHK: begin
          if (match_key) begin
            state_d = S_PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d = S_RELEASED;
              valid_d = 1'b0;
            end
          end
        end
        default: state_d = S_RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: strobes one column low per dwell period, gathers a
// frame of four column samples and hands a single-key result to the debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DWELL_CYCLES    = 100000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master bus
);

  localparam int DW_W = $clog2(DWELL_CYCLES);

  logic [DW_W-1:0] dwell_q;
  logic [1:0]      col_idx_q;
  logic [3:0]      col_q;
  logic [3:0]      row_meta_q, row_sync_q;
  logic [1:0]      acc_hits_q;
  logic [3:0]      acc_code_q;

  logic            dwell_end;
  logic [2:0]      samp_hits, hit_sum;
  logic [1:0]      samp_row, tot_hits;
  logic [3:0]      samp_code, tot_code;
  logic            frame_tick, frame_valid;
  logic [3:0]      frame_code;
  logic [3:0]      key_code;
  logic            key_valid, key_pulse;

  assign dwell_end = (dwell_q == DW_W'(DWELL_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q    <= '0;
      col_idx_q  <= '0;
      col_q      <= COL_RESET;
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
      acc_hits_q <= '0;
      acc_code_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop here sees pre-edge values of the others.
      row_meta_q <= bus.row;
      row_sync_q <= row_meta_q;
      if (dwell_end) begin
        dwell_q   <= '0;
        col_q     <= {col_q[2:0], col_q[3]};
        col_idx_q <= col_idx_q + 2'd1;
        if (col_idx_q == 2'd3) begin
          acc_hits_q <= '0;
          acc_code_q <= '0;
        end else begin
          acc_hits_q <= tot_hits;
          acc_code_q <= tot_code;
        end
      end else begin
        dwell_q <= dwell_q + DW_W'(1);
      end
    end
  end

  // Hit count saturates at 2: anything beyond one key is simply "not a single key".
  always_comb begin
    samp_hits = '0;
    samp_row  = '0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_q[r]) begin
        samp_hits = samp_hits + 3'd1;
        samp_row  = 2'(r);
      end
    end
  end

  assign samp_code   = key_lut(samp_row, col_idx_q);
  assign hit_sum     = {1'b0, acc_hits_q} + samp_hits;
  assign tot_hits    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
  assign tot_code    = (samp_hits == 3'd1) ? samp_code : acc_code_q;

  assign frame_tick  = dwell_end && (col_idx_q == 2'd3);
  assign frame_valid = (tot_hits == 2'd1);
  assign frame_code  = tot_code;

  keypad_debounce_fsm #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .frame_valid(frame_valid),
    .frame_code (frame_code),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_pulse  (key_pulse)
  );

  assign bus.col       = col_q;
  assign bus.key_code  = key_code;
  assign bus.key_valid = key_valid;
  assign bus.key_pulse = key_pulse;

endmodule
